// File: rtl/eye_bbox_measure_pkg.sv
// Shared frame geometry, eye ROI defaults and the common types used by the
// eye-tracking blocks.
package eye_bbox_measure_pkg;

    localparam int COORD_W = 11;
    localparam int CNT_W   = 11;

    // Default 800x480 panel with the two eye windows side by side
    localparam int H_ACT_DEF   = 800;
    localparam int V_ACT_DEF   = 480;
    localparam int ROI1_X0_DEF = 100;
    localparam int ROI1_X1_DEF = 399;
    localparam int ROI2_X0_DEF = 400;
    localparam int ROI2_X1_DEF = 699;
    localparam int ROI_Y0_DEF  = 100;
    localparam int ROI_Y1_DEF  = 379;
    localparam int MIN_PIX_DEF = 16;

    localparam logic [COORD_W-1:0] COORD_MIN_INIT = 11'h7FF;
    localparam logic [COORD_W-1:0] COORD_MAX_INIT = 11'h000;
    localparam logic [CNT_W-1:0]   CNT_SAT        = 11'h7FF;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        LATCH    = 2'd2
    } meas_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
        logic [CNT_W-1:0]   cnt;
    } bbox_acc_t;

    // Empty box: min above any coordinate, max below, so the first hit sets both
    localparam bbox_acc_t ACC_INIT = '{
        x_min: COORD_MIN_INIT,
        x_max: COORD_MAX_INIT,
        y_min: COORD_MIN_INIT,
        y_max: COORD_MAX_INIT,
        cnt:   '0
    };

endpackage

// File: rtl/eye_bbox_measure_acc.sv
// Per-eye bounding-box accumulator: tracks min/max x/y and a saturating count
// of dark pixels falling inside one rectangular ROI.
module eye_bbox_acc
    import eye_bbox_measure_pkg::*;
#(
    parameter int X0 = ROI1_X0_DEF,
    parameter int X1 = ROI1_X1_DEF,
    parameter int Y0 = ROI_Y0_DEF,
    parameter int Y1 = ROI_Y1_DEF
)
(
    input  logic               module_clk,
    input  logic               module_rst_n,
    input  logic               acc_clr,
    input  logic               acc_en,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               eye_pix,
    output bbox_acc_t          acc
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_SAT) ? c : c + 1'b1;
    endfunction

    logic      in_roi;
    logic      hit;
    bbox_acc_t base;
    bbox_acc_t acc_nxt;

    assign in_roi = (xpos >= COORD_W'(X0)) && (xpos <= COORD_W'(X1)) &&
                    (ypos >= COORD_W'(Y0)) && (ypos <= COORD_W'(Y1));
    assign hit    = acc_en && eye_pix && in_roi;

    // A clear folds in the current pixel so a frame start is never lost
    always_comb begin
        base    = acc_clr ? ACC_INIT : acc;
        acc_nxt = base;
        if (hit) begin
            if (xpos < base.x_min) acc_nxt.x_min = xpos;
            if (xpos > base.x_max) acc_nxt.x_max = xpos;
            if (ypos < base.y_min) acc_nxt.y_min = ypos;
            if (ypos > base.y_max) acc_nxt.y_max = ypos;
            acc_nxt.cnt = sat_inc(base.cnt);
        end
    end

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            acc <= ACC_INIT;
        end else if (acc_clr || hit) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/eye_bbox_measure.sv
// Measures the dark-pixel bounding box of two eye ROIs over each full frame and
// presents the previous frame's height/width, pulsing frame_done on update.
module eye_bbox_measure
    import eye_bbox_measure_pkg::*;
#(
    parameter int H_ACT   = H_ACT_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    parameter int ROI1_X0 = ROI1_X0_DEF,
    parameter int ROI1_X1 = ROI1_X1_DEF,
    parameter int ROI2_X0 = ROI2_X0_DEF,
    parameter int ROI2_X1 = ROI2_X1_DEF,
    parameter int ROI_Y0  = ROI_Y0_DEF,
    parameter int ROI_Y1  = ROI_Y1_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF
)
(
    input  logic               module_clk,
    input  logic               module_rst_n,
    input  logic [COORD_W-1:0] lcd_pixel_xpos,
    input  logic [COORD_W-1:0] lcd_pixel_ypos,
    input  logic               eye_pix,
    output logic [COORD_W-1:0] eye1_high,
    output logic [COORD_W-1:0] eye1_Wide,
    output logic [COORD_W-1:0] eye2_high,
    output logic [COORD_W-1:0] eye2_Wide,
    output logic               frame_done
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

    // Empty or too sparse boxes report zero size
    function automatic logic [COORD_W-1:0] box_len(
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi,
        input logic [CNT_W-1:0]   cnt
    );
        if ((cnt != '0) && (cnt >= MIN_CNT)) return hi - lo + 1'b1;
        return '0;
    endfunction

    meas_state_e state_q;
    meas_state_e state_d;
    logic        pix_act;
    logic        sof;
    logic        eof;
    logic        acc_clr;
    logic        acc_en;
    logic        latch_en;
    bbox_acc_t   acc1;
    bbox_acc_t   acc2;

    assign pix_act = (lcd_pixel_xpos != '0) && (lcd_pixel_xpos <= COORD_W'(H_ACT)) &&
                     (lcd_pixel_ypos != '0) && (lcd_pixel_ypos <= COORD_W'(V_ACT));
    assign sof     = (lcd_pixel_xpos == COORD_W'(1)) && (lcd_pixel_ypos == COORD_W'(1));
    assign eof     = (lcd_pixel_xpos == COORD_W'(H_ACT)) && (lcd_pixel_ypos == COORD_W'(V_ACT));

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (sof) state_d = ACCUM;
            ACCUM:    if (eof) state_d = LATCH;
            LATCH:    state_d = ACCUM;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // A start of frame seen while accumulating means the frame was cut short;
    // the partial data is dropped and the outputs are left alone.
    always_comb begin
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                acc_clr = sof;
                acc_en  = pix_act && sof;
            end
            ACCUM: begin
                acc_clr = sof;
                acc_en  = pix_act;
            end
            LATCH: begin
                acc_clr  = 1'b1;
                acc_en   = pix_act;
                latch_en = 1'b1;
            end
            default: ;
        endcase
    end

    eye_bbox_acc #(
        .X0 (ROI1_X0),
        .X1 (ROI1_X1),
        .Y0 (ROI_Y0),
        .Y1 (ROI_Y1)
    ) u_eye1_acc (
        .module_clk   (module_clk),
        .module_rst_n (module_rst_n),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .xpos         (lcd_pixel_xpos),
        .ypos         (lcd_pixel_ypos),
        .eye_pix      (eye_pix),
        .acc          (acc1)
    );

    eye_bbox_acc #(
        .X0 (ROI2_X0),
        .X1 (ROI2_X1),
        .Y0 (ROI_Y0),
        .Y1 (ROI_Y1)
    ) u_eye2_acc (
        .module_clk   (module_clk),
        .module_rst_n (module_rst_n),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .xpos         (lcd_pixel_xpos),
        .ypos         (lcd_pixel_ypos),
        .eye_pix      (eye_pix),
        .acc          (acc2)
    );

    // Outputs and frame_done update together on the edge closing the LATCH cycle
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            eye1_high  <= '0;
            eye1_Wide  <= '0;
            eye2_high  <= '0;
            eye2_Wide  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= latch_en;
            if (latch_en) begin
                eye1_high <= box_len(acc1.y_min, acc1.y_max, acc1.cnt);
                eye1_Wide <= box_len(acc1.x_min, acc1.x_max, acc1.cnt);
                eye2_high <= box_len(acc2.y_min, acc2.y_max, acc2.cnt);
                eye2_Wide <= box_len(acc2.x_min, acc2.x_max, acc2.cnt);
            end
        end
    end

endmodule

// File: tb/tb_eye_bbox_measure.sv
// Scoreboard bench for eye_bbox_measure on a reduced frame: frames are built as
// dark-pixel maps, the expected boxes come from scanning the map directly.
module tb_eye_bbox_measure;

    localparam int H    = 100;
    localparam int V    = 60;
    localparam int R1X0 = 10;
    localparam int R1X1 = 50;
    localparam int R2X0 = 51;
    localparam int R2X1 = 90;
    localparam int RY0  = 5;
    localparam int RY1  = 54;
    localparam int MINP = 16;

    typedef struct {
        int e1h;
        int e1w;
        int e2h;
        int e2w;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [10:0] xpos    = '0;
    logic [10:0] ypos    = '0;
    logic        eye_pix = 1'b0;
    logic [10:0] e1h, e1w, e2h, e2w;
    logic        fd;

    exp_t exp_q[$];
    exp_t cur = '{0, 0, 0, 0};
    int   checks   = 0;
    int   failures = 0;
    int   n_pushed = 0;
    int   n_pulses = 0;
    bit   dark [1:V][1:H];

    always #5 clk = ~clk;

    eye_bbox_measure #(
        .H_ACT   (H),
        .V_ACT   (V),
        .ROI1_X0 (R1X0),
        .ROI1_X1 (R1X1),
        .ROI2_X0 (R2X0),
        .ROI2_X1 (R2X1),
        .ROI_Y0  (RY0),
        .ROI_Y1  (RY1),
        .MIN_PIX (MINP)
    ) dut (
        .module_clk     (clk),
        .module_rst_n   (rst_n),
        .lcd_pixel_xpos (xpos),
        .lcd_pixel_ypos (ypos),
        .eye_pix        (eye_pix),
        .eye1_high      (e1h),
        .eye1_Wide      (e1w),
        .eye2_high      (e2h),
        .eye2_Wide      (e2w),
        .frame_done     (fd)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, "_eye1_high"}, int'(e1h), e.e1h);
        chk({tag, "_eye1_Wide"}, int'(e1w), e.e1w);
        chk({tag, "_eye2_high"}, int'(e2h), e.e2h);
        chk({tag, "_eye2_Wide"}, int'(e2w), e.e2w);
    endtask

    // Reference: scan the whole map for dark pixels inside the eye window
    function automatic void eye_box(input int x0, input int x1, output int hgt, output int wid);
        int n = 0;
        int xmn = H + 1, xmx = 0, ymn = V + 1, ymx = 0;
        for (int y = 1; y <= V; y++)
            for (int x = 1; x <= H; x++)
                if (dark[y][x] && x >= x0 && x <= x1 && y >= RY0 && y <= RY1) begin
                    n++;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
        if (n > 2047) n = 2047;
        if (n >= MINP) begin
            hgt = ymx - ymn + 1;
            wid = xmx - xmn + 1;
        end else begin
            hgt = 0;
            wid = 0;
        end
    endfunction

    task automatic clr_frame();
        for (int y = 1; y <= V; y++)
            for (int x = 1; x <= H; x++)
                dark[y][x] = 1'b0;
    endtask

    task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                dark[y][x] = 1'b1;
    endtask

    task automatic add_rand(input int n);
        for (int i = 0; i < n; i++)
            dark[$urandom_range(1, V)][$urandom_range(1, H)] = 1'b1;
    endtask

    task automatic blank_cycle();
        xpos    = '0;
        eye_pix = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    // Scan rows start_row..stop_row; only a full, reset-free scan expects an update
    task automatic drive_frame(input int start_row, input int stop_row, input int rst_row,
                               input int tail_gap);
        exp_t e;
        bit   complete;
        complete = (start_row == 1) && (stop_row == V) && (rst_row == 0);
        for (int y = start_row; y <= stop_row; y++) begin
            for (int x = 1; x <= H; x++) begin
                if (rst_row != 0 && y == rst_row && x == 1) begin
                    rst_n = 1'b0;
                    #1;
                    chk_outs("rst_async", '{0, 0, 0, 0});
                    chk("rst_async_frame_done", int'(fd), 0);
                end
                if (rst_row != 0 && y == rst_row && x == 6) rst_n = 1'b1;
                if (complete && y == V && x == H) begin
                    eye_box(R1X0, R1X1, e.e1h, e.e1w);
                    eye_box(R2X0, R2X1, e.e2h, e.e2w);
                    exp_q.push_back(e);
                    n_pushed++;
                end
                xpos    = 11'(x);
                ypos    = 11'(y);
                eye_pix = dark[y][x];
                @(posedge clk); #1;
            end
            if (!(y == V && tail_gap == 0) && $urandom_range(0, 1) == 1) blank_cycle();
        end
        ypos = '0;
        for (int i = 0; i < tail_gap; i++) blank_cycle();
    endtask

    // Monitor: reset forces zero, frame_done pops the scoreboard, start of
    // frame must still show the last completed frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur = '{0, 0, 0, 0};
            chk_outs("in_reset", cur);
            chk("in_reset_frame_done", int'(fd), 0);
        end else if (fd) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                chk("frame_done_unexpected", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                chk_outs("frame_done", cur);
            end
        end else if (xpos == 11'd1 && ypos == 11'd1) begin
            chk_outs("hold_at_sof", cur);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset_state", '{0, 0, 0, 0});
        chk("reset_state_frame_done", int'(fd), 0);
        rst_n = 1'b1;
        repeat (2) blank_cycle();

        // Tail of a frame before any start-of-frame: must not latch
        clr_frame(); add_rect(12, 48, 30, 50);
        drive_frame(30, V, 0, 3);

        // Rectangle in eye 1 only, plus dark pixels just outside both ROIs
        clr_frame(); add_rect(15, 54 - 20, 20, 29);
        dark[20][9] = 1'b1; dark[4][30] = 1'b1; dark[30][91] = 1'b1; dark[55][60] = 1'b1;
        drive_frame(1, V, 0, 4);

        // Height-20 box in eye 1, ten scattered dark pixels in eye 2
        clr_frame(); add_rect(20, 29, 10, 29);
        for (int i = 0; i < 10; i++) dark[10 + 4 * i][55 + 3 * i] = 1'b1;
        drive_frame(1, V, 0, 0);

        // Height-5 box, started straight after the previous frame's last pixel
        clr_frame(); add_rect(20, 29, 30, 34);
        drive_frame(1, V, 0, 2);

        // Block straddling the ROI split plus the last ROI row
        clr_frame(); add_rect(47, 54, 5, 8); add_rect(50, 51, 54, 54);
        drive_frame(1, V, 0, 3);

        // Truncated frame: restarts at (1,1) without reaching the end
        clr_frame(); add_rect(11, 50, 6, 40); add_rect(60, 80, 6, 40);
        drive_frame(1, 30, 0, 2);

        clr_frame(); add_rand(60);
        drive_frame(1, V, 0, 1);

        // Reset asserted halfway down a frame holding a box
        clr_frame(); add_rect(20, 40, 20, 45);
        drive_frame(1, V, V / 2, 3);

        // Whole eye-1 window dark: count exceeds the saturation point
        clr_frame(); add_rect(R1X0, R1X1, RY0, RY1); add_rect(60, 63, 40, 43);
        drive_frame(1, V, 0, 3);

        clr_frame();
        add_rect($urandom_range(5, 30), $urandom_range(31, 55), $urandom_range(1, 20), $urandom_range(21, 58));
        add_rect($urandom_range(45, 70), $urandom_range(71, 98), $urandom_range(3, 25), $urandom_range(26, 60));
        add_rand(30);
        drive_frame(1, V, 0, 3);

        repeat (10) blank_cycle();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("frame_done_pulses", n_pulses, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
